text_buffer_arbiter: RTL and testbench
======================================

Name: text_buffer_arbiter

Overview:
Arbitrates the single read/write port of the text-editor character buffer between two requesters:
- the terminal writer, which emits one-cycle write strobes that cannot be back-pressured;
- a read client, such as the source fetcher for the assembler, using a valid/ready handshake.

Writes normally win. A 4-entry write FIFO absorbs terminal writes when a starving reader is granted. Read-after-write ordering is preserved by hazard stalling. The block sits between terminal_controller/reader and the text_editor BRAM.

Parameters:
SCREEN_WIDTH, 76, characters per row.
SCREEN_HEIGHT, 256, rows in buffer.
ADDR_WIDTH, $clog2(SCREEN_WIDTH*SCREEN_HEIGHT) (=15), buffer address width.
DATA_WIDTH, 8, character code width.
WFIFO_DEPTH, 4, write-holding FIFO entries (power of two).
STARVE_LIMIT, 8, blocked-read cycles before read gains priority.
MEM_LATENCY, 2, BRAM read latency from registered address to valid mem_dout_in.

Ports:
pixel_clk_in  input  1  system clock
rst_in  input  1  asynchronous active-high reset
wr_en_in  input  1  terminal write strobe, single cycle, never stalled
wr_addr_in  input  ADDR_WIDTH  terminal write address
wr_data_in  input  DATA_WIDTH  terminal write character
rd_valid_in  input  1  read request pending
rd_addr_in  input  ADDR_WIDTH  read address, held stable while rd_valid_in && !rd_ready_out
rd_ready_out  output  1  read accepted this cycle (combinational)
rd_data_valid_out  output  1  read data strobe
rd_data_out  output  DATA_WIDTH  read data
mem_we_out  output  1  BRAM write enable (registered)
mem_addr_out  output  ADDR_WIDTH  BRAM address (registered)
mem_din_out  output  DATA_WIDTH  BRAM write data (registered)
mem_dout_in  input  DATA_WIDTH  BRAM read data
fifo_count_out  output  $clog2(WFIFO_DEPTH)+1  write FIFO occupancy

Behaviour:
Clock and reset:
- One clock, pixel_clk_in.
- rst_in is asynchronous and active-high.

Reset state:
- All outputs 0.
- FIFO empty.
- starve_cnt 0.
- Read-tag pipeline cleared.

Definitions:
- hazard = rd_addr_in matches any valid FIFO entry.
- starving = starve_cnt >= STARVE_LIMIT.
- full = fifo_count_out == WFIFO_DEPTH.

Per-cycle decision (first matching rule wins):
1. STARVE_READ: rd_valid_in && starving && !hazard && !full.
   - Grant the read.
   - If wr_en_in, push the incoming write into the FIFO.
2. DRAIN: FIFO non-empty.
   - Issue the FIFO head write (pop).
   - If wr_en_in, push the incoming write; count is unchanged on simultaneous push+pop.
3. BYPASS: wr_en_in with FIFO empty.
   - Issue the incoming write directly; the FIFO is untouched.
4. READ: rd_valid_in && !hazard.
   - Grant the read.
5. IDLE:
   - mem_we_out <= 0; mem_addr_out holds.

Overflow:
- Impossible by construction: a push without a pop only occurs in rule 1, which requires !full.

Read response:
- rd_ready_out = 1 only in the cycle rule 1 or 4 fires.
- The memory port is registered, so the BRAM sees the address at grant+1.
- rd_data_valid_out pulses exactly at grant+1+MEM_LATENCY, with rd_data_out = mem_dout_in that cycle.
- This timing is tracked by a (1+MEM_LATENCY)-deep valid shift register.
- Back-to-back grants produce back-to-back responses.

starve_cnt:
- Increments (saturating at STARVE_LIMIT) each cycle rd_valid_in && !rd_ready_out.
- Clears on a grant or when rd_valid_in is low.

Ordering:
- A read granted in the same cycle as a write to the same address (rule 1 push) returns the old data. The read is ordered before that write.
- A read whose address is in the FIFO waits until that entry drains, so it returns the new data.
- FIFO writes drain in order.

Reset mid-operation:
- Pending FIFO writes and in-flight reads are discarded.
- No rd_data_valid_out pulses after reset asserts.

Liveness:
- A read can be starved only by sustained writes on ≥ every cycle with a full FIFO. Terminal write rate makes this unreachable in practice.
- The bench checks the read is granted within STARVE_LIMIT+WFIFO_DEPTH+1 cycles under a one-write-per-2-cycle load.

Decomposition:
- Package text_buffer_pkg:
  - SCREEN_WIDTH/SCREEN_HEIGHT defaults and ADDR_WIDTH localparam;
  - char_t (logic [7:0]);
  - tb_addr_t;
  - typedef struct wr_entry_t {tb_addr_t addr; char_t data;};
  - enum grant_e {G_IDLE, G_BYPASS, G_DRAIN, G_READ, G_STARVE_READ} for debug visibility.
- Sub-module text_wr_fifo: circular FIFO of wr_entry_t, with push/pop/count and a parallel addr-match output (hazard CAM).

Test Plan:
1. Reset: assert rst_in asynchronously mid-cycle -> all outputs 0 immediately; fifo_count_out=0.
2. Bypass write: wr_en_in at addr 0x0010 data 0x41, no reads -> next cycle mem_we_out=1, mem_addr_out=0x0010, mem_din_out=0x41; fifo_count_out stays 0.
3. Idle read: rd_valid_in, addr 0x0123, BRAM preloaded 0x5A -> rd_ready_out=1 same cycle; rd_data_valid_out=1 with rd_data_out=0x5A exactly 3 cycles later; five consecutive reads give five consecutive pulses.
4. Starvation: continuous read request while writes arrive every cycle -> read granted on cycle 9 (after 8 blocked); that cycle's write lands in FIFO (count 1) and drains next cycle.
5. Hazard: FIFO holds a write to 0x0200 data 0x33, read requests 0x0200 -> rd_ready_out held 0 until the entry drains; response data = 0x33.
6. Full FIFO, starving read, write strobe present -> rule 1 suppressed, DRAIN fires; no write lost; count never exceeds 4.

Source files
------------

// File: rtl/text_buffer_pkg.sv
// Shared types for the text-buffer arbiter slice.
// Buffer geometry, entry layout and grant encoding.
package text_buffer_pkg;

  localparam int SCREEN_WIDTH  = 76;
  localparam int SCREEN_HEIGHT = 256;
  localparam int ADDR_WIDTH    =
    $clog2(SCREEN_WIDTH * SCREEN_HEIGHT);
  localparam int DATA_WIDTH    = 8;

  typedef logic [DATA_WIDTH-1:0] char_t;
  typedef logic [ADDR_WIDTH-1:0] tb_addr_t;

  typedef struct packed {
    tb_addr_t addr;
    char_t    data;
  } wr_entry_t;

  typedef enum logic [2:0] {
    G_IDLE,
    G_BYPASS,
    G_DRAIN,
    G_READ,
    G_STARVE_READ
  } grant_e;

endpackage

// File: rtl/text_buffer_arbiter_wr_fifo.sv
// Circular write-holding FIFO with an address
// match across all occupied slots.
module text_wr_fifo
  import text_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wr_entry_t                push_entry,
  input  logic                     pop,
  output wr_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  input  tb_addr_t                 match_addr,
  output logic                     match
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wr_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   rel [DEPTH];

  assign head = mem[rd_ptr];

  // Slot distance from head, used to tell live slots apart.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rel[i] = PW'(i) - rd_ptr;
    end
  end

  // Address hit on any live slot.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(rel[i]) < count) &&
          (mem[i].addr == match_addr))
        match = 1'b1;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; liveness comes from count, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/text_buffer_arbiter.sv
// Shares the editor buffer BRAM port between the
// terminal writer and a handshaked read client.
module text_buffer_arbiter
  import text_buffer_pkg::*;
#(
  parameter int WFIFO_DEPTH  = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int MEM_LATENCY  = 2
) (
  input  logic                         pixel_clk_in,
  input  logic                         rst_in,
  input  logic                         wr_en_in,
  input  logic [ADDR_WIDTH-1:0]        wr_addr_in,
  input  logic [DATA_WIDTH-1:0]        wr_data_in,
  input  logic                         rd_valid_in,
  input  logic [ADDR_WIDTH-1:0]        rd_addr_in,
  output logic                         rd_ready_out,
  output logic                         rd_data_valid_out,
  output logic [DATA_WIDTH-1:0]        rd_data_out,
  output logic                         mem_we_out,
  output logic [ADDR_WIDTH-1:0]        mem_addr_out,
  output logic [DATA_WIDTH-1:0]        mem_din_out,
  input  logic [DATA_WIDTH-1:0]        mem_dout_in,
  output logic [$clog2(WFIFO_DEPTH):0] fifo_count_out
);

  localparam int CW = $clog2(WFIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0]        starve_cnt;
  logic [MEM_LATENCY:0] rd_pipe;
  logic                 hazard;
  logic                 starving;
  logic                 full;
  logic                 empty;
  logic                 s_starve;
  logic                 s_drain;
  logic                 s_bypass;
  logic                 s_read;
  logic                 push;
  wr_entry_t            head;
  wr_entry_t            in_entry;
  grant_e               grant;

  assign in_entry = '{addr: wr_addr_in, data: wr_data_in};

  text_wr_fifo #(
    .DEPTH(WFIFO_DEPTH)
  ) u_fifo (
    .clk        (pixel_clk_in),
    .rst        (rst_in),
    .push       (push),
    .push_entry (in_entry),
    .pop        (s_drain),
    .head       (head),
    .count      (fifo_count_out),
    .match_addr (rd_addr_in),
    .match      (hazard)
  );

  assign starving = starve_cnt >= SW'(STARVE_LIMIT);
  assign full     = fifo_count_out == CW'(WFIFO_DEPTH);
  assign empty    = fifo_count_out == '0;

  // Mutually exclusive rule terms in priority order.
  assign s_starve = rd_valid_in && starving &&
                    !hazard && !full;
  assign s_drain  = !s_starve && !empty;
  assign s_bypass = !s_starve && empty && wr_en_in;
  assign s_read   = !s_starve && empty && !wr_en_in &&
                    rd_valid_in && !hazard;

  assign push = wr_en_in && (s_starve || s_drain);

  assign rd_ready_out = (s_starve || s_read) && !rst_in;

  // Grant encoding, also handy on a waveform.
  always_comb begin
    grant = G_IDLE;
    unique case (1'b1)
      s_starve: grant = G_STARVE_READ;
      s_drain:  grant = G_DRAIN;
      s_bypass: grant = G_BYPASS;
      s_read:   grant = G_READ;
      default:  grant = G_IDLE;
    endcase
  end

  // Registered BRAM port driven by the granted source.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_we_out   <= 1'b0;
      mem_addr_out <= '0;
      mem_din_out  <= '0;
    end else begin
      unique case (grant)
        G_DRAIN: begin
          mem_we_out   <= 1'b1;
          mem_addr_out <= head.addr;
          mem_din_out  <= head.data;
        end
        G_BYPASS: begin
          mem_we_out   <= 1'b1;
          mem_addr_out <= wr_addr_in;
          mem_din_out  <= wr_data_in;
        end
        G_READ, G_STARVE_READ: begin
          mem_we_out   <= 1'b0;
          mem_addr_out <= rd_addr_in;
        end
        default: mem_we_out <= 1'b0;
      endcase
    end
  end

  // Count consecutive blocked read cycles, saturating.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      starve_cnt <= '0;
    end else if (!rd_valid_in || rd_ready_out) begin
      starve_cnt <= '0;
    end else if (!starving) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Grant tag follows the address through the BRAM.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe <= {rd_pipe[MEM_LATENCY-1:0], rd_ready_out};
    end
  end

  assign rd_data_valid_out = rd_pipe[MEM_LATENCY];
  assign rd_data_out = rd_data_valid_out ? mem_dout_in : '0;

endmodule

// File: tb/tb_text_buffer_arbiter.sv
// Directed bench for text_buffer_arbiter with a
// two-cycle BRAM model and write/read scoreboards.
module tb_text_buffer_arbiter;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        rd_valid;
  logic [14:0] rd_addr;
  logic        rd_ready;
  logic        rd_dv;
  logic [7:0]  rd_data;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [2:0]  fcount;

  logic        pl_en;
  logic [14:0] pl_addr;
  logic [7:0]  pl_data;
  logic [7:0]  bram [0:32767];
  logic [7:0]  rd_s1;

  int n_chk;
  int n_pass;

  logic [22:0] wq[$];
  logic [7:0]  rq[$];

  typedef struct {
    logic        we;
    logic [14:0] wa;
    logic [7:0]  wd;
    logic        rv;
    logic [14:0] ra;
    logic        e_rdy;
    logic        e_we;
    logic [14:0] e_a;
    logic [7:0]  e_d;
    logic [2:0]  e_cnt;
    logic [7:0]  e_rd;
  } vec_t;

  vec_t tbl [7];

  text_buffer_arbiter dut (
    .pixel_clk_in      (clk),
    .rst_in            (rst),
    .wr_en_in          (wr_en),
    .wr_addr_in        (wr_addr),
    .wr_data_in        (wr_data),
    .rd_valid_in       (rd_valid),
    .rd_addr_in        (rd_addr),
    .rd_ready_out      (rd_ready),
    .rd_data_valid_out (rd_dv),
    .rd_data_out       (rd_data),
    .mem_we_out        (mem_we),
    .mem_addr_out      (mem_addr),
    .mem_din_out       (mem_din),
    .mem_dout_in       (mem_dout),
    .fifo_count_out    (fcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: registered address, two-cycle read.
  always @(posedge clk) begin
    rd_s1    <= bram[mem_addr];
    mem_dout <= rd_s1;
    if (mem_we) bram[mem_addr] <= mem_din;
    else if (pl_en) bram[pl_addr] <= pl_data;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Writes reach BRAM in strobe order; reads return expected data.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      if (wq.size() == 0) begin
        n_chk++;
        $display("FAIL wr_unexpected: addr %0h data %0h",
                 mem_addr, mem_din);
      end else begin
        logic [22:0] e;
        e = wq.pop_front();
        chk("sb_wr_addr", 32'(mem_addr), 32'(e[22:8]));
        chk("sb_wr_data", 32'(mem_din), 32'(e[7:0]));
      end
    end
    if (rd_dv) begin
      if (rq.size() == 0) begin
        n_chk++;
        $display("FAIL rd_unexpected: data %0h", rd_data);
      end else begin
        logic [7:0] d;
        d = rq.pop_front();
        chk("sb_rd_data", 32'(rd_data), 32'(d));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we,
                       input logic [14:0] wa,
                       input logic [7:0] wd,
                       input logic rv,
                       input logic [14:0] ra);
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    rd_valid = rv;
    rd_addr  = ra;
    if (we) wq.push_back({wa, wd});
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 15'h0, 8'h0, 1'b0, 15'h0);
      tick();
    end
  endtask

  task automatic preload(input logic [14:0] a,
                         input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},   32'(mem_we),   0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_din"},  32'(mem_din),  0);
    chk({tag, "_rdy"},  32'(rd_ready), 0);
    chk({tag, "_dv"},   32'(rd_dv),    0);
    chk({tag, "_rdat"}, 32'(rd_data),  0);
    chk({tag, "_cnt"},  32'(fcount),   0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] bits;
    logic       got;
    int         maxc;

    n_chk = 0; n_pass = 0;
    rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    rd_valid = 0; rd_addr = 0;

    tick();
    preload(15'h123, 8'h5A);
    preload(15'h124, 8'h5B);
    preload(15'h125, 8'h5C);
    preload(15'h126, 8'h5D);
    preload(15'h127, 8'h5E);
    preload(15'h300, 8'h77);
    preload(15'h400, 8'h11);
    preload(15'h200, 8'h99);
    preload(15'h500, 8'h22);
    preload(15'h600, 8'h66);
    rd_valid = 1'b1; rd_addr = 15'h123; #1;
    chk_all_zero("rst0");
    rd_valid = 1'b0;
    tick();
    rst = 1'b0;

    // Directed single-cycle vectors from a clean idle state.
    tbl[0] = '{1'b1, 15'h010, 8'h41, 1'b0, 15'h000,
               1'b0, 1'b1, 15'h010, 8'h41, 3'd0, 8'h00};
    tbl[1] = '{1'b0, 15'h000, 8'h00, 1'b0, 15'h000,
               1'b0, 1'b0, 15'h010, 8'h41, 3'd0, 8'h00};
    tbl[2] = '{1'b0, 15'h000, 8'h00, 1'b1, 15'h123,
               1'b1, 1'b0, 15'h123, 8'h41, 3'd0, 8'h5A};
    tbl[3] = '{1'b1, 15'h020, 8'h42, 1'b1, 15'h124,
               1'b0, 1'b1, 15'h020, 8'h42, 3'd0, 8'h00};
    tbl[4] = '{1'b0, 15'h000, 8'h00, 1'b1, 15'h124,
               1'b1, 1'b0, 15'h124, 8'h42, 3'd0, 8'h5B};
    tbl[5] = '{1'b1, 15'h030, 8'h43, 1'b0, 15'h000,
               1'b0, 1'b1, 15'h030, 8'h43, 3'd0, 8'h00};
    tbl[6] = '{1'b0, 15'h000, 8'h00, 1'b0, 15'h000,
               1'b0, 1'b0, 15'h030, 8'h43, 3'd0, 8'h00};

    foreach (tbl[i]) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd,
            tbl[i].rv, tbl[i].ra);
      chk($sformatf("v%0d_rdy", i), 32'(rd_ready),
          32'(tbl[i].e_rdy));
      if (tbl[i].e_rdy) rq.push_back(tbl[i].e_rd);
      tick();
      chk($sformatf("v%0d_we", i), 32'(mem_we),
          32'(tbl[i].e_we));
      chk($sformatf("v%0d_addr", i), 32'(mem_addr),
          32'(tbl[i].e_a));
      chk($sformatf("v%0d_din", i), 32'(mem_din),
          32'(tbl[i].e_d));
      chk($sformatf("v%0d_cnt", i), 32'(fcount),
          32'(tbl[i].e_cnt));
    end
    idle(4);

    // Read latency: pulse exactly three cycles after grant.
    drive(1'b0, 15'h0, 8'h0, 1'b1, 15'h123);
    chk("lat_rdy", 32'(rd_ready), 1);
    rq.push_back(8'h5A);
    tick();
    drive(1'b0, 15'h0, 8'h0, 1'b0, 15'h0);
    chk("lat_dv1", 32'(rd_dv), 0);
    tick();
    chk("lat_dv2", 32'(rd_dv), 0);
    tick();
    chk("lat_dv3", 32'(rd_dv), 1);
    chk("lat_data", 32'(rd_data), 32'h5A);
    idle(3);

    // Five back-to-back grants, five back-to-back pulses.
    bits = '0;
    for (int j = 0; j < 9; j++) begin
      if (j < 5) begin
        drive(1'b0, 15'h0, 8'h0, 1'b1, 15'(32'h123 + j));
        chk($sformatf("b2b_rdy%0d", j), 32'(rd_ready), 1);
        rq.push_back(8'(32'h5A + j));
      end else begin
        drive(1'b0, 15'h0, 8'h0, 1'b0, 15'h0);
      end
      bits[j] = rd_dv;
      tick();
    end
    chk("b2b_pulses", 32'(bits), 32'h0F8);
    idle(3);

    // Starvation: writes every cycle, read wins on cycle 9.
    for (int c = 1; c <= 9; c++) begin
      drive(1'b1, 15'(32'h1000 + c), 8'(c),
            1'b1, 15'h300);
      chk($sformatf("stv_rdy%0d", c), 32'(rd_ready),
          32'(c == 9));
      if (c == 9) rq.push_back(8'h77);
      tick();
    end
    chk("stv_cnt1", 32'(fcount), 1);
    chk("stv_we0", 32'(mem_we), 0);
    chk("stv_raddr", 32'(mem_addr), 32'h300);
    drive(1'b0, 15'h0, 8'h0, 1'b0, 15'h0);
    tick();
    chk("stv_cnt0", 32'(fcount), 0);
    chk("stv_drain_we", 32'(mem_we), 1);
    chk("stv_drain_a", 32'(mem_addr), 32'h1009);
    idle(4);

    // Hazard: read of an address still in the FIFO waits.
    for (int c = 1; c <= 9; c++) begin
      if (c == 9)
        drive(1'b1, 15'h200, 8'h33, 1'b1, 15'h400);
      else
        drive(1'b1, 15'(32'h1100 + c), 8'(32'h80 + c),
              1'b1, 15'h400);
      if (c == 9) rq.push_back(8'h11);
      tick();
    end
    chk("hz_cnt1", 32'(fcount), 1);
    drive(1'b0, 15'h0, 8'h0, 1'b1, 15'h200);
    chk("hz_blocked", 32'(rd_ready), 0);
    tick();
    chk("hz_cnt0", 32'(fcount), 0);
    chk("hz_granted", 32'(rd_ready), 1);
    rq.push_back(8'h33);
    tick();
    idle(5);

    // Full FIFO: starving read deferred, nothing lost.
    maxc = 0;
    for (int c = 1; c <= 46; c++) begin
      drive(c <= 45, 15'(32'h2000 + c), 8'(c),
            1'b1, 15'h500);
      if (c == 45) chk("full_cnt", 32'(fcount), 4);
      chk($sformatf("full_rdy%0d", c), 32'(rd_ready),
          32'(c == 9 || c == 18 || c == 27 || c == 36));
      if (c == 9 || c == 18 || c == 27 || c == 36)
        rq.push_back(8'h22);
      tick();
      if (int'(fcount) > maxc) maxc = int'(fcount);
    end
    drive(1'b0, 15'h0, 8'h0, 1'b1, 15'h500);
    chk("full_after_rdy", 32'(rd_ready), 1);
    rq.push_back(8'h22);
    tick();
    idle(6);
    chk("full_max_cnt", 32'(maxc), 4);
    chk("full_drained", 32'(fcount), 0);

    // Liveness under one write every other cycle.
    got = 1'b0;
    for (int c = 1; c <= 13 && !got; c++) begin
      drive(c[0], 15'(32'h3000 + c), 8'(c),
            1'b1, 15'h600);
      if (rd_ready) begin
        got = 1'b1;
        rq.push_back(8'h66);
      end
      tick();
    end
    chk("live_grant", 32'(got), 1);
    idle(6);

    // Asynchronous reset mid-operation.
    drive(1'b0, 15'h0, 8'h0, 1'b1, 15'h124);
    tick();
    drive(1'b1, 15'h050, 8'h45, 1'b0, 15'h0);
    tick();
    chk("mid_we_pre", 32'(mem_we), 1);
    rd_valid = 1'b1; rd_addr = 15'h125;
    rst = 1'b1;
    wq.delete();
    rq.delete();
    #1;
    chk_all_zero("midrst");
    wr_en = 1'b0; rd_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    idle(6);

    chk("end_wq_empty", 32'(wq.size()), 0);
    chk("end_rq_empty", 32'(rq.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
